// File: rtl/pb_reduction_offload_arbiter_pkg.sv
// Shared definitions for the reduction offload arbiter.
// - Default wide/narrow data widths and opcode width of the router offload ports.
// - Requester ID encoding carried through the in-flight ID FIFO.
// - Reduction opcode type.
package pb_reduction_offload_arbiter_pkg;

  localparam int unsigned WideDataW       = 512;
  localparam int unsigned NarrowDataW     = 64;
  localparam int unsigned RedOpW          = 4;
  localparam int unsigned DefaultMaxOutst = 4;

  // Requester ID: which router issued an ALU operation.
  typedef enum logic {
    REQ_ID_WIDE   = 1'b0,
    REQ_ID_NARROW = 1'b1
  } req_id_e;

  typedef logic [RedOpW-1:0] reduction_op_t;

endpackage

// File: rtl/pb_reduction_offload_arbiter_fifo_v3.sv
// fifo_v3: small synchronous FIFO with occupancy output.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (empties the FIFO)
//   flush_i            synchronous clear
//   full_o, empty_o    status
//   usage_o            occupancy, clog2(DEPTH)+1 bits
//   data_i / push_i    write side (push ignored when full)
//   data_o / pop_i     read side, data_o shows the head (pop ignored when empty)
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CntW-1:0]       usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  // Pointers wrap explicitly at DEPTH-1 so the modulo holds for any depth.
  function automatic logic [AddrW-1:0] ptr_next(input logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign usage_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pb_reduction_offload_arbiter.sv
// pb_reduction_offload_arbiter: shares one in-order reduction ALU between the
// wide and narrow router offload requesters.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   wide_req_* / wide_resp_*      wide requester (WideW operands/result)
//   narrow_req_* / narrow_resp_*  narrow requester (NarrowW operands/result)
//   alu_req_* / alu_resp_*        shared ALU request and response ports
//   dbg_state_o                   FSM state (0 = IDLE, 1 = HOLD)
//   dbg_fifo_usage_o              number of ALU operations in flight
// Handshakes: every port pair is valid/ready; a transfer happens on the rising
// edge where both are high. Once alu_req_valid_o is raised it stays high, with
// grant/op/operands stable, until alu_req_ready_i accepts it.
module pb_reduction_offload_arbiter
  import pb_reduction_offload_arbiter_pkg::*;
#(
  parameter int unsigned WideW    = WideDataW,
  parameter int unsigned NarrowW  = NarrowDataW,
  parameter int unsigned OpW      = RedOpW,
  parameter int unsigned MaxOutst = DefaultMaxOutst,
  localparam int unsigned CntW    = $clog2(MaxOutst) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [OpW-1:0]     wide_req_op_i,
  input  logic [WideW-1:0]   wide_req_operand1_i,
  input  logic [WideW-1:0]   wide_req_operand2_i,
  input  logic               wide_req_valid_i,
  output logic               wide_req_ready_o,
  output logic [WideW-1:0]   wide_resp_result_o,
  output logic               wide_resp_valid_o,
  input  logic               wide_resp_ready_i,
  input  logic [OpW-1:0]     narrow_req_op_i,
  input  logic [NarrowW-1:0] narrow_req_operand1_i,
  input  logic [NarrowW-1:0] narrow_req_operand2_i,
  input  logic               narrow_req_valid_i,
  output logic               narrow_req_ready_o,
  output logic [NarrowW-1:0] narrow_resp_result_o,
  output logic               narrow_resp_valid_o,
  input  logic               narrow_resp_ready_i,
  output logic [OpW-1:0]     alu_req_op_o,
  output logic [WideW-1:0]   alu_req_operand1_o,
  output logic [WideW-1:0]   alu_req_operand2_o,
  output logic               alu_req_valid_o,
  input  logic               alu_req_ready_i,
  input  logic [WideW-1:0]   alu_resp_result_i,
  input  logic               alu_resp_valid_i,
  output logic               alu_resp_ready_o,
  output logic               dbg_state_o,
  output logic [CntW-1:0]    dbg_fifo_usage_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]       state_q, state_d;
  req_id_e          last_grant_q, hold_grant_q, grant_id, head_id;
  logic             grant_valid, req_hs, resp_hs;
  logic             fifo_full, fifo_empty;
  logic [0:0]       push_id, fifo_head;
  logic [WideW-1:0] narrow_op1_ext, narrow_op2_ext;

  // Grant selection. HOLD replays the stored grant; IDLE arbitrates
  // round-robin. The FIFO full flag is used directly, so a response popping
  // in the same cycle does not open a slot for a new grant yet.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_ID_WIDE;
    if (state_q == StHold) begin
      grant_valid = 1'b1;
      grant_id    = hold_grant_q;
    end else if (!fifo_full) begin
      if (wide_req_valid_i && narrow_req_valid_i) begin
        grant_valid = 1'b1;
        grant_id    = (last_grant_q == REQ_ID_NARROW) ? REQ_ID_WIDE : REQ_ID_NARROW;
      end else if (wide_req_valid_i) begin
        grant_valid = 1'b1;
        grant_id    = REQ_ID_WIDE;
      end else if (narrow_req_valid_i) begin
        grant_valid = 1'b1;
        grant_id    = REQ_ID_NARROW;
      end
    end
    // Outputs are forced quiet while reset is asserted.
    if (!rst_ni) grant_valid = 1'b0;
  end

  always_comb begin
    narrow_op1_ext = '0;
    narrow_op2_ext = '0;
    narrow_op1_ext[NarrowW-1:0] = narrow_req_operand1_i;
    narrow_op2_ext[NarrowW-1:0] = narrow_req_operand2_i;
  end

  always_comb begin
    alu_req_op_o       = '0;
    alu_req_operand1_o = '0;
    alu_req_operand2_o = '0;
    if (grant_valid) begin
      if (grant_id == REQ_ID_WIDE) begin
        alu_req_op_o       = wide_req_op_i;
        alu_req_operand1_o = wide_req_operand1_i;
        alu_req_operand2_o = wide_req_operand2_i;
      end else begin
        alu_req_op_o       = narrow_req_op_i;
        alu_req_operand1_o = narrow_op1_ext;
        alu_req_operand2_o = narrow_op2_ext;
      end
    end
  end

  assign alu_req_valid_o    = grant_valid;
  assign req_hs             = grant_valid && alu_req_ready_i;
  assign wide_req_ready_o   = req_hs && (grant_id == REQ_ID_WIDE);
  assign narrow_req_ready_o = req_hs && (grant_id == REQ_ID_NARROW);

  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      if (grant_valid && !alu_req_ready_i) state_d = StHold;
    end else begin
      if (alu_req_ready_i) state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= REQ_ID_NARROW;
      hold_grant_q <= REQ_ID_WIDE;
    end else begin
      state_q <= state_d;
      if (req_hs) last_grant_q <= grant_id;
      if (state_q == StIdle && state_d == StHold) hold_grant_q <= grant_id;
    end
  end

  // In-flight requester IDs, in ALU issue order.
  assign push_id = grant_id;

  fifo_v3 #(
    .DATA_WIDTH (1),
    .DEPTH      (MaxOutst)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (dbg_fifo_usage_o),
    .data_i  (push_id),
    .push_i  (req_hs),
    .data_o  (fifo_head),
    .pop_i   (resp_hs)
  );

  // Response steering follows the FIFO head; nothing is routed while empty.
  assign head_id             = req_id_e'(fifo_head);
  assign alu_resp_ready_o    = !fifo_empty &&
                               ((head_id == REQ_ID_WIDE) ? wide_resp_ready_i : narrow_resp_ready_i);
  assign wide_resp_valid_o   = !fifo_empty && (head_id == REQ_ID_WIDE) && alu_resp_valid_i;
  assign narrow_resp_valid_o = !fifo_empty && (head_id == REQ_ID_NARROW) && alu_resp_valid_i;
  assign resp_hs             = alu_resp_valid_i && alu_resp_ready_o;
  assign wide_resp_result_o   = rst_ni ? alu_resp_result_i : '0;
  assign narrow_resp_result_o = rst_ni ? alu_resp_result_i[NarrowW-1:0] : '0;

  assign dbg_state_o = state_q;

  // A response with nothing in flight means the ALU and this block disagree.
  resp_without_request_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(alu_resp_valid_i && fifo_empty)
  );

endmodule

// File: tb/tb_pb_reduction_offload_arbiter.sv
module tb_pb_reduction_offload_arbiter;

  localparam int WideW   = 512;
  localparam int NarrowW = 64;
  localparam int OpW     = 4;
  localparam int CntW    = 3;
  localparam int W       = WideW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic [OpW-1:0]     wide_req_op_i, narrow_req_op_i, alu_req_op_o;
  logic [WideW-1:0]   wide_req_operand1_i, wide_req_operand2_i, wide_resp_result_o;
  logic [NarrowW-1:0] narrow_req_operand1_i, narrow_req_operand2_i, narrow_resp_result_o;
  logic               wide_req_valid_i, wide_req_ready_o, wide_resp_valid_o, wide_resp_ready_i;
  logic               narrow_req_valid_i, narrow_req_ready_o, narrow_resp_valid_o, narrow_resp_ready_i;
  logic [WideW-1:0]   alu_req_operand1_o, alu_req_operand2_o, alu_resp_result_i;
  logic               alu_req_valid_o, alu_req_ready_i, alu_resp_valid_i, alu_resp_ready_o;
  logic               dbg_state_o;
  logic [CntW-1:0]    dbg_fifo_usage_o;

  pb_reduction_offload_arbiter dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .wide_req_op_i         (wide_req_op_i),
    .wide_req_operand1_i   (wide_req_operand1_i),
    .wide_req_operand2_i   (wide_req_operand2_i),
    .wide_req_valid_i      (wide_req_valid_i),
    .wide_req_ready_o      (wide_req_ready_o),
    .wide_resp_result_o    (wide_resp_result_o),
    .wide_resp_valid_o     (wide_resp_valid_o),
    .wide_resp_ready_i     (wide_resp_ready_i),
    .narrow_req_op_i       (narrow_req_op_i),
    .narrow_req_operand1_i (narrow_req_operand1_i),
    .narrow_req_operand2_i (narrow_req_operand2_i),
    .narrow_req_valid_i    (narrow_req_valid_i),
    .narrow_req_ready_o    (narrow_req_ready_o),
    .narrow_resp_result_o  (narrow_resp_result_o),
    .narrow_resp_valid_o   (narrow_resp_valid_o),
    .narrow_resp_ready_i   (narrow_resp_ready_i),
    .alu_req_op_o          (alu_req_op_o),
    .alu_req_operand1_o    (alu_req_operand1_o),
    .alu_req_operand2_o    (alu_req_operand2_o),
    .alu_req_valid_o       (alu_req_valid_o),
    .alu_req_ready_i       (alu_req_ready_i),
    .alu_resp_result_i     (alu_resp_result_i),
    .alu_resp_valid_i      (alu_resp_valid_i),
    .alu_resp_ready_o      (alu_resp_ready_o),
    .dbg_state_o           (dbg_state_o),
    .dbg_fifo_usage_o      (dbg_fifo_usage_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]     exp_q[$];  // {requester id, expected result} in issue order
  logic [WideW-1:0] alu_q[$];  // results the ALU model still owes
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [WideW-1:0] alu_fn(input logic [OpW-1:0] op,
                                              input logic [WideW-1:0] a, input logic [WideW-1:0] b);
    return a + b + WideW'(op);
  endfunction

  function automatic logic [WideW-1:0] rand_wide();
    logic [WideW-1:0] r;
    for (int i = 0; i < WideW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic void check(input string name, input logic [WideW-1:0] act,
                                input logic [WideW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_resp(input logic id, input logic [WideW-1:0] data);
    logic [W-1:0]     e;
    logic [WideW-1:0] e_data;
    if (exp_q.size() == 0) begin
      check("resp_unexpected", 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    e_data = e[WideW-1:0];
    check("resp_id", id, e[WideW]);
    if (id) check("resp_narrow_data", data, WideW'(e_data[NarrowW-1:0]));
    else    check("resp_wide_data", data, e_data);
  endfunction

  // Called once per cycle at the sample point (inputs stable, before the edge).
  function automatic void observe();
    if (alu_req_valid_o && alu_req_ready_i)
      alu_q.push_back(alu_fn(alu_req_op_o, alu_req_operand1_o, alu_req_operand2_o));
    if (wide_req_valid_i && wide_req_ready_o)
      exp_q.push_back({1'b0, alu_fn(wide_req_op_i, wide_req_operand1_i, wide_req_operand2_i)});
    if (narrow_req_valid_i && narrow_req_ready_o)
      exp_q.push_back({1'b1, alu_fn(narrow_req_op_i, WideW'(narrow_req_operand1_i),
                                    WideW'(narrow_req_operand2_i))});
    if (wide_resp_valid_o && wide_resp_ready_i) check_resp(1'b0, wide_resp_result_o);
    if (narrow_resp_valid_o && narrow_resp_ready_i) check_resp(1'b1, WideW'(narrow_resp_result_o));
    if (alu_resp_valid_i && alu_resp_ready_o && alu_q.size() > 0) void'(alu_q.pop_front());
  endfunction

  // ---------------- driver tasks ----------------
  task automatic settle();
    #1;
  endtask

  task automatic advance();
    observe();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wide_req_valid_i    = 1'b0;
    narrow_req_valid_i  = 1'b0;
    alu_req_ready_i     = 1'b0;
    alu_resp_valid_i    = 1'b0;
    alu_resp_result_i   = '0;
    wide_resp_ready_i   = 1'b0;
    narrow_resp_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    alu_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_resp(input logic en);
    alu_resp_valid_i  = en && (alu_q.size() > 0);
    alu_resp_result_i = (alu_q.size() > 0) ? alu_q[0] : '0;
  endtask

  task automatic drain();
    wide_resp_ready_i   = 1'b1;
    narrow_resp_ready_i = 1'b1;
    for (int i = 0; i < 20 && alu_q.size() > 0; i++) begin
      drive_resp(1'b1);
      settle();
      advance();
    end
    alu_resp_valid_i = 1'b0;
    check("drain_done", (alu_q.size() == 0) && (exp_q.size() == 0), 1'b1);
    check("drain_usage", dbg_fifo_usage_o, 0);
  endtask

  task automatic set_wide(input logic [OpW-1:0] op, input logic [WideW-1:0] a,
                          input logic [WideW-1:0] b);
    wide_req_op_i = op; wide_req_operand1_i = a; wide_req_operand2_i = b;
  endtask

  task automatic set_narrow(input logic [OpW-1:0] op, input logic [NarrowW-1:0] a,
                            input logic [NarrowW-1:0] b);
    narrow_req_op_i = op; narrow_req_operand1_i = a; narrow_req_operand2_i = b;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           wv, nv, ar;
    logic           e_valid, e_wready, e_nready;
    logic [CntW-1:0] e_usage;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Arbitration from a fresh reset with the ALU always ready.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};  // tie -> wide
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};  // tie -> narrow
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2};  // tie -> wide
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3};  // tie -> narrow
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};  // full: stalled
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};

    set_wide('0, '0, '0);
    set_narrow('0, '0, '0);
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);

    // Reset: outputs quiet even with requests pending.
    wide_req_valid_i = 1'b1; narrow_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    wide_resp_ready_i = 1'b1; narrow_resp_ready_i = 1'b1;
    alu_resp_result_i = rand_wide();
    set_wide(4'd1, rand_wide(), rand_wide());
    settle();
    check("rst_alu_valid", alu_req_valid_o, 0);
    check("rst_wide_ready", wide_req_ready_o, 0);
    check("rst_narrow_ready", narrow_req_ready_o, 0);
    check("rst_operand1", alu_req_operand1_o, 0);
    check("rst_alu_resp_ready", alu_resp_ready_o, 0);
    check("rst_wide_resp_valid", wide_resp_valid_o, 0);
    check("rst_wide_result", wide_resp_result_o, 0);
    check("rst_usage", dbg_fifo_usage_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(negedge clk);
    clear_inputs();
    rst_ni = 1'b1;
    @(negedge clk);

    // Single wide request: op 2, operands 5 and 7.
    set_wide(4'd2, 512'd5, 512'd7);
    wide_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    settle();
    check("t1_alu_valid", alu_req_valid_o, 1);
    check("t1_wide_ready", wide_req_ready_o, 1);
    check("t1_narrow_ready", narrow_req_ready_o, 0);
    check("t1_op", alu_req_op_o, 2);
    check("t1_operand1", alu_req_operand1_o, 5);
    check("t1_operand2", alu_req_operand2_o, 7);
    advance();
    wide_req_valid_i = 1'b0;
    settle();
    check("t1_usage", dbg_fifo_usage_o, 1);
    check("t1_state", dbg_state_o, 0);
    drain();

    // Table: round-robin ties and FIFO-full stall.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wide_req_valid_i = vecs[i].wv; narrow_req_valid_i = vecs[i].nv; alu_req_ready_i = vecs[i].ar;
      set_wide(4'($urandom_range(0, 15)), rand_wide(), rand_wide());
      set_narrow(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
      settle();
      check($sformatf("vec%0d_valid", i), alu_req_valid_o, vecs[i].e_valid);
      check($sformatf("vec%0d_wready", i), wide_req_ready_o, vecs[i].e_wready);
      check($sformatf("vec%0d_nready", i), narrow_req_ready_o, vecs[i].e_nready);
      check($sformatf("vec%0d_usage", i), dbg_fifo_usage_o, vecs[i].e_usage);
      advance();
    end

    // Full with a pop in the same cycle: still no grant; issue resumes next cycle.
    wide_req_valid_i = 1'b1; narrow_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    wide_resp_ready_i = 1'b1; narrow_resp_ready_i = 1'b1;
    drive_resp(1'b1);
    settle();
    check("full_pop_alu_valid", alu_req_valid_o, 0);
    check("full_pop_resp_ready", alu_resp_ready_o, 1);
    check("full_pop_wide_resp_valid", wide_resp_valid_o, 1);
    check("full_pop_narrow_resp_valid", narrow_resp_valid_o, 0);
    advance();
    alu_resp_valid_i = 1'b0;
    settle();
    check("resume_usage", dbg_fifo_usage_o, 3);
    check("resume_alu_valid", alu_req_valid_o, 1);
    check("resume_wide_ready", wide_req_ready_o, 1);
    advance();
    wide_req_valid_i = 1'b0; narrow_req_valid_i = 1'b0;

    // In-order responses; narrow head stalled by narrow_resp_ready_i=0.
    narrow_resp_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_resp(1'b1);
      settle();
      check("stall_alu_resp_ready", alu_resp_ready_o, 0);
      check("stall_narrow_resp_valid", narrow_resp_valid_o, 1);
      check("stall_wide_resp_valid", wide_resp_valid_o, 0);
      advance();
    end
    narrow_resp_ready_i = 1'b1;
    drive_resp(1'b1);
    settle();
    check("unstall_alu_resp_ready", alu_resp_ready_o, 1);
    advance();
    narrow_resp_ready_i = 1'b0;
    drive_resp(1'b1);
    settle();
    check("wide_head_resp_ready", alu_resp_ready_o, 1);
    check("wide_head_resp_valid", wide_resp_valid_o, 1);
    advance();
    drain();

    // Narrow 0xFF held by ALU backpressure; a late wide request must not steal the grant.
    do_reset();
    set_narrow(4'd3, 64'hFF, 64'hFF);
    set_wide(4'd1, rand_wide(), rand_wide());
    narrow_req_valid_i = 1'b1; alu_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) wide_req_valid_i = 1'b1;
      settle();
      check("hold_valid", alu_req_valid_o, 1);
      check("hold_operand1", alu_req_operand1_o, 512'hFF);
      check("hold_narrow_ready", narrow_req_ready_o, 0);
      check("hold_wide_ready", wide_req_ready_o, 0);
      if (i > 0) check("hold_state", dbg_state_o, 1);
      advance();
    end
    alu_req_ready_i = 1'b1;
    settle();
    check("hold_release_nready", narrow_req_ready_o, 1);
    check("hold_release_wready", wide_req_ready_o, 0);
    check("hold_release_op", alu_req_op_o, 3);
    advance();
    narrow_req_valid_i = 1'b0;
    settle();
    check("after_hold_state", dbg_state_o, 0);
    check("after_hold_wready", wide_req_ready_o, 1);
    advance();
    wide_req_valid_i = 1'b0;
    drain();

    // Reset with two operations in flight.
    set_wide(4'd5, rand_wide(), rand_wide());
    set_narrow(4'd6, {$urandom, $urandom}, {$urandom, $urandom});
    wide_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    settle(); advance();
    wide_req_valid_i = 1'b0; narrow_req_valid_i = 1'b1;
    settle(); advance();
    narrow_req_valid_i = 1'b0;
    settle();
    check("inflight_usage", dbg_fifo_usage_o, 2);
    rst_ni = 1'b0;
    wide_req_valid_i = 1'b1; narrow_req_valid_i = 1'b1;
    wide_resp_ready_i = 1'b1; narrow_resp_ready_i = 1'b1;
    alu_resp_result_i = rand_wide();
    settle();
    check("mid_rst_alu_valid", alu_req_valid_o, 0);
    check("mid_rst_wready", wide_req_ready_o, 0);
    check("mid_rst_nready", narrow_req_ready_o, 0);
    check("mid_rst_operand1", alu_req_operand1_o, 0);
    check("mid_rst_alu_resp_ready", alu_resp_ready_o, 0);
    check("mid_rst_narrow_resp_valid", narrow_resp_valid_o, 0);
    check("mid_rst_narrow_result", narrow_resp_result_o, 0);
    check("mid_rst_usage", dbg_fifo_usage_o, 0);
    alu_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    settle();
    check("post_rst_wready", wide_req_ready_o, 1);
    check("post_rst_nready", narrow_req_ready_o, 0);
    advance();
    wide_req_valid_i = 1'b0; narrow_req_valid_i = 1'b0;
    drain();

    // ---------------- final report ----------------
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_reduction_offload_arbiter.md
PB_REDUCTION_OFFLOAD_ARBITER -- requirements
Module: pb_reduction_offload_arbiter

Interface
REQ-001 SHALL have parameter WideW, default 512, meaning wide operand/result width in bits.
REQ-002 SHALL have parameter NarrowW, default 64, meaning narrow operand/result width in bits (NarrowW <= WideW).
REQ-003 SHALL have parameter OpW, default 4, meaning reduction opcode width.
REQ-004 SHALL have parameter MaxOutst, default 4, meaning maximum in-flight ALU operations (power of two, >= 2).
REQ-005 SHALL have clk_i, input, 1, the single clock.
REQ-006 SHALL have rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have wide_req_op_i / wide_req_operand1_i / wide_req_operand2_i, inputs, OpW / WideW / WideW, the wide router offload request.
REQ-008 SHALL have wide_req_valid_i (in, 1), wide_req_ready_o (out, 1), wide_resp_result_o (out, WideW), wide_resp_valid_o (out, 1), wide_resp_ready_i (in, 1).
REQ-009 SHALL have the same narrow_* set with NarrowW operand/result widths.
REQ-010 SHALL have alu_req_op_o (out, OpW), alu_req_operand1_o / alu_req_operand2_o (out, WideW), alu_req_valid_o (out, 1), alu_req_ready_i (in, 1): the shared reduction ALU request port.
REQ-011 SHALL have alu_resp_result_i (in, WideW), alu_resp_valid_i (in, 1), alu_resp_ready_o (out, 1): the shared ALU response port.

Function
REQ-012 SHALL share one in-order ALU between the wide and narrow requesters; all handshakes SHALL be valid/ready, with a transfer on the rising edge where both are high.
REQ-013 SHALL run a two-state FSM, IDLE and HOLD; in IDLE, with at least one requester valid and the ID FIFO not full, it SHALL grant a requester combinationally, drive alu_req_valid_o=1, and enter HOLD if alu_req_ready_i=0.
REQ-014 In HOLD, grant, op and operands SHALL stay stable and alu_req_valid_o SHALL stay 1 until alu_req_ready_i=1; it SHALL then return to IDLE.
REQ-015 Arbitration SHALL be round-robin: a 1-bit last_grant register updates on every ALU request handshake; when both requesters are valid, the one not in last_grant wins; reset value of last_grant SHALL be narrow, so wide wins the first tie.
REQ-016 Narrow operands SHALL be zero-extended to WideW on alu_req_operand*_o; narrow_resp_result_o SHALL be alu_resp_result_i[NarrowW-1:0].
REQ-017 wide_req_ready_o / narrow_req_ready_o SHALL equal alu_req_ready_i gated by that requester's grant; they SHALL never both be 1.
REQ-018 On each ALU request handshake, the granted requester ID (0=wide, 1=narrow) SHALL be pushed into an ID FIFO of depth MaxOutst.
REQ-019 While the FIFO is full, no new grant SHALL be issued (alu_req_valid_o=0 in IDLE), even if a pop occurs in the same cycle.
REQ-020 alu_resp_ready_o SHALL equal the resp_ready_i of the requester at the FIFO head; alu_resp_valid_i SHALL be routed only to that requester's resp_valid_o; the other resp_valid_o SHALL be 0.
REQ-021 Each response handshake SHALL pop the FIFO; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-022 With the FIFO empty, alu_resp_ready_o SHALL be 0 and both resp_valid_o SHALL be 0; alu_resp_valid_i=1 while empty is a protocol error and SHALL fire an assertion.
REQ-023 The FIFO pointers SHALL wrap modulo MaxOutst; the occupancy counter SHALL be clog2(MaxOutst)+1 bits wide.
REQ-024 Request-to-ALU latency SHALL be 0 cycles (combinational); the block SHALL add no response latency.

Reset
REQ-025 On rst_ni=0, the FSM SHALL go to IDLE, the FIFO SHALL empty, and last_grant SHALL be narrow; all valid/ready outputs SHALL be 0 and all data outputs SHALL be 0 during reset.
REQ-026 A reset mid-operation SHALL discard in-flight IDs; the ALU SHALL be reset in the same domain.

Structure
REQ-027 The requester ID encoding and the reduction opcode type SHALL live in the shared picobello package; the widths SHALL come from the NoC package AXI configs.
REQ-028 The ID FIFO SHALL be the sub-module fifo_v3 (common_cells), instantiated with DATA_WIDTH=1 and DEPTH=MaxOutst.

Verification
REQ-029 The bench SHALL cover: single wide request op=2, operands 5 and 7, with alu_req_ready_i=1 -> same-cycle alu_req_valid_o, wide_req_ready_o=1, FIFO count 1.
REQ-030 The bench SHALL cover: both requesters valid for 4 cycles with the ALU always ready -> grants wide, narrow, wide, narrow.
REQ-031 The bench SHALL cover: narrow operands 0xFF with alu_req_ready_i=0 for 3 cycles -> alu_req_operand1_o = zero-extended 0xFF, held stable 3 cycles, narrow_req_ready_o=0 throughout.
REQ-032 The bench SHALL cover: 4 grants with no responses (MaxOutst=4) -> 5th request stalled with alu_req_valid_o=0; one response pops -> issue resumes the next cycle.
REQ-033 The bench SHALL cover: responses returned for W,N,W -> delivered in order to wide, narrow, wide; narrow_resp_ready_i=0 stalls alu_resp_ready_o.
REQ-034 The bench SHALL cover: rst_ni asserted with 2 operations in flight -> all outputs 0 and FIFO empty; the next request is granted to wide.
